// File: rtl/uart_sha256_bridge.sv
// uart_sha256_bridge: receives framed payloads over an 8N1 UART, hashes them
// with SHA-256 and answers with a status byte followed by the digest.
// Frame: 0x01, LEN_HI, LEN_LO, then exactly LEN payload bytes (any value).
// Ports:
//   clk        system clock (only clock)
//   rst        synchronous active-high reset
//   uart_rx    serial input, idle high
//   uart_tx    serial output, idle high
//   busy       high whenever the bridge is not idle
//   err_count  saturating count of rejected frames
// Sub-modules uart_rx_core, uart_tx_core and sha256_processor live here too.

module uart_rx_core #(parameter int BAUD_DIV = 868) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  logic          rx_meta, rx_sync, active;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1; rx_sync <= 1'b1; active <= 1'b0;
      cnt <= '0; bit_idx <= '0; shift <= '0; data <= '0; valid <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      valid   <= 1'b0;
      if (!active) begin
        // Falling edge: first sample lands mid start bit.
        if (!rx_sync) begin
          active <= 1'b1; cnt <= CW'(BAUD_DIV / 2); bit_idx <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= CW'(BAUD_DIV - 1);
        if (bit_idx == 4'd0) begin
          if (rx_sync) active <= 1'b0;   // glitch, not a start bit
          else bit_idx <= 4'd1;
        end else if (bit_idx <= 4'd8) begin
          shift   <= {rx_sync, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end else begin
          active <= 1'b0;
          if (rx_sync) begin data <= shift; valid <= 1'b1; end
        end
      end
    end
  end
endmodule

module uart_tx_core #(parameter int BAUD_DIV = 868) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1; busy <= 1'b0; cnt <= '0; bit_idx <= '0; shift <= '1;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1; tx <= 1'b0; shift <= {1'b1, data};
        cnt <= CW'(BAUD_DIV - 1); bit_idx <= '0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= CW'(BAUD_DIV - 1);
      // Nine shifted symbols (8 data + stop); the tenth tick ends the frame.
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
      end else begin
        tx      <= shift[0];
        shift   <= {1'b1, shift[8:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
endmodule

// Byte-streaming SHA-256 with internal padding. A block compression takes
// 65 cycles, so bytes must arrive further apart than that (one UART byte
// time is 10*BAUD_DIV cycles, which covers it for any BAUD_DIV >= 7).
module sha256_processor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         data_last,
  output logic [255:0] hash_out,
  output logic         done
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {P_IDLE, P_LOAD, P_PAD, P_COMP, P_ADD} pstate_t;
  pstate_t     st;
  logic [31:0] h [8];
  logic [31:0] v [8];   // working variables a..h
  logic [31:0] w [16];  // sliding message-schedule window, w[0] = W_t
  logic [5:0]  ptr, rnd;
  logic [15:0] nbytes;
  logic        pad80, len_blk, fin, pad_next;
  logic [31:0] t1, t2, w_new;
  logic [63:0] bitlen;
  logic [7:0]  pad_byte;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    bitlen = {45'd0, nbytes, 3'd0};
    // 0x80 first, then zeros; the length goes into bytes 56..63 of the
    // block that is known to be the last one (len_blk).
    if (!pad80)                         pad_byte = 8'h80;
    else if (len_blk && ptr >= 6'd56)   pad_byte = bitlen[{~ptr[2:0], 3'b000} +: 8];
    else                                pad_byte = 8'h00;
  end

  assign hash_out = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= P_IDLE; done <= 1'b0; ptr <= '0; rnd <= '0; nbytes <= '0;
      pad80 <= 1'b0; len_blk <= 1'b0; fin <= 1'b0; pad_next <= 1'b0;
      for (int i = 0; i < 8; i++) begin h[i] <= '0; v[i] <= '0; end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < 8; i++) h[i] <= IV[i];
      st <= P_LOAD; done <= 1'b0; ptr <= '0; nbytes <= '0;
      pad80 <= 1'b0; len_blk <= 1'b0; fin <= 1'b0; pad_next <= 1'b0;
    end else begin
      case (st)
        P_LOAD: if (data_valid) begin
          w[ptr[5:2]][{~ptr[1:0], 3'b000} +: 8] <= data_in;
          ptr    <= ptr + 1'b1;
          nbytes <= nbytes + 16'd1;
          if (ptr == 6'd63) begin
            st <= P_COMP; rnd <= '0; fin <= 1'b0; pad_next <= data_last;
            for (int i = 0; i < 8; i++) v[i] <= h[i];
          end else if (data_last) begin
            st <= P_PAD;
          end
        end
        P_PAD: begin
          w[ptr[5:2]][{~ptr[1:0], 3'b000} +: 8] <= pad_byte;
          ptr <= ptr + 1'b1;
          if (!pad80) begin
            pad80 <= 1'b1;
            if (ptr <= 6'd55) len_blk <= 1'b1;
          end
          if (ptr == 6'd63) begin
            st <= P_COMP; rnd <= '0; fin <= len_blk; pad_next <= 1'b1;
            len_blk <= 1'b1;   // any further block is the length block
            for (int i = 0; i < 8; i++) v[i] <= h[i];
          end
        end
        P_COMP: begin
          v[7] <= v[6]; v[6] <= v[5]; v[5] <= v[4]; v[4] <= v[3] + t1;
          v[3] <= v[2]; v[2] <= v[1]; v[1] <= v[0]; v[0] <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          rnd   <= rnd + 1'b1;
          if (rnd == 6'd63) st <= P_ADD;
        end
        P_ADD: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
          if (fin) begin done <= 1'b1; st <= P_IDLE; end
          else st <= pad_next ? P_PAD : P_LOAD;
        end
        default: ;
      endcase
    end
  end
endmodule

module uart_sha256_bridge #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int MAX_LEN     = 1024,
  parameter int HEX_OUT     = 0,
  parameter int TIMEOUT_CYC = 16 * (CLK_FREQ / BAUD) * 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       busy,
  output logic [7:0] err_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int NDIG     = (HEX_OUT != 0) ? 64 : 32;

  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, START, PAYLOAD, WAIT_DONE,
                            SEND_STATUS, SEND_DIGEST, DRAIN} state_t;
  state_t       state;
  logic [7:0]   rx_data, len_hi, status, tx_data, proc_data, digest_byte;
  logic         rx_valid, tx_busy, tx_start, proc_start, proc_valid, proc_last, done;
  logic [15:0]  cnt, len_val;
  logic [31:0]  timer;
  logic [255:0] hash, digest;
  logic [5:0]   idx;
  logic [3:0]   nib;
  logic         can_tx;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (.clk(clk), .rst(rst), .rx(uart_rx),
                                            .data(rx_data), .valid(rx_valid));
  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (.clk(clk), .rst(rst), .start(tx_start),
                                            .data(tx_data), .tx(uart_tx), .busy(tx_busy));
  sha256_processor u_sha (.clk(clk), .rst(rst), .start(proc_start), .data_in(proc_data),
                          .data_valid(proc_valid), .data_last(proc_last),
                          .hash_out(hash), .done(done));

  assign busy    = (state != IDLE);
  assign len_val = {len_hi, rx_data};
  // tx_busy rises one cycle after tx_start, so the pending start also blocks.
  assign can_tx  = !tx_busy && !tx_start;

  always_comb begin
    nib = digest[{~idx, 2'b00} +: 4];
    if (HEX_OUT != 0)
      digest_byte = (nib < 4'd10) ? 8'h30 + {4'd0, nib} : 8'h57 + {4'd0, nib};
    else
      digest_byte = digest[{~idx[4:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; err_count <= '0; len_hi <= '0; cnt <= '0; timer <= '0;
      status <= '0; digest <= '0; idx <= '0; tx_start <= 1'b0; tx_data <= '0;
      proc_start <= 1'b0; proc_data <= '0; proc_valid <= 1'b0; proc_last <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      proc_start <= 1'b0;
      proc_valid <= 1'b0;
      proc_last  <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_valid && rx_data == 8'h01) state <= LEN_HI;
        end
        LEN_HI, LEN_LO, PAYLOAD: begin
          if (rx_valid) begin
            timer <= '0;
            if (state == LEN_HI) begin
              len_hi <= rx_data;
              state  <= LEN_LO;
            end else if (state == LEN_LO) begin
              if (len_val == 16'd0 || len_val > 16'(MAX_LEN)) begin
                status <= 8'hE1;
                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                state <= SEND_STATUS;
              end else begin
                cnt   <= len_val;
                state <= START;
              end
            end else begin
              proc_data  <= rx_data;
              proc_valid <= 1'b1;
              proc_last  <= (cnt == 16'd1);
              cnt        <= cnt - 1'b1;
              if (cnt == 16'd1) state <= WAIT_DONE;
            end
          end else if (timer == 32'(TIMEOUT_CYC - 1)) begin
            status <= 8'hE2;
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            state <= SEND_STATUS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        START: begin
          proc_start <= 1'b1;
          state      <= PAYLOAD;
        end
        WAIT_DONE: if (done) begin
          digest <= hash; status <= 8'h00; idx <= '0; state <= SEND_STATUS;
        end
        SEND_STATUS: if (can_tx) begin
          tx_start <= 1'b1;
          tx_data  <= status;
          state    <= (status == 8'h00) ? SEND_DIGEST : DRAIN;
        end
        SEND_DIGEST: if (can_tx) begin
          tx_start <= 1'b1;
          tx_data  <= digest_byte;
          if (idx == 6'(NDIG - 1)) begin idx <= '0; state <= DRAIN; end
          else idx <= idx + 1'b1;
        end
        DRAIN: if (can_tx) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
